// File: rtl/native2wb_pkg.sv
// native2wb_pkg: shared types and constants for the native-to-Wishbone bridge.
package native2wb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    WB_WR = 3'd2,
    WB_RD = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/native2wb_watchdog.sv
// wb_watchdog: loadable down-counter; expired_c is high once the count reaches zero.
// Instantiated by native2wb only when NATIVE2WB_TIMEOUT_EN is defined.
module wb_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  // Load LIMIT-1 on entry, then count down once per enabled cycle, saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LIMIT - 1);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/native2wb.sv
// native2wb: native cmd/wdata/rdata port to classic single-cycle Wishbone master.
// Optional watchdog on Wishbone cycles: define NATIVE2WB_TIMEOUT_EN.
module native2wb
  import native2wb_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 256,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(32'h0200_0000),
  parameter int unsigned          TIMEOUT   = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_payload_we,
  input  logic [ADDR_W-1:0]     cmd_payload_addr,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_W-1:0]     wdata_payload_data,
  input  logic [DATA_W/8-1:0]   wdata_payload_we,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_W-1:0]     rdata_payload_data,
  output logic [ADDR_W-1:0]     wb_adr,
  output logic [DATA_W-1:0]     wb_dat_w,
  input  logic [DATA_W-1:0]     wb_dat_r,
  output logic [DATA_W/8-1:0]   wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [2:0]            wb_cti,
  output logic [1:0]            wb_bte,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  output logic                  bus_error
);

  localparam int unsigned SEL_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [DATA_W-1:0]   dat_w_d;
  logic [SEL_W-1:0]    sel_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                we_d, cyc_d, rvalid_d, err_d;
  logic                busy;
  logic                timeout;

  assign busy        = (state_q == WB_WR) || (state_q == WB_RD);
  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WDATA);
  assign wb_cti      = CTI_CLASSIC;
  assign wb_bte      = BTE_LINEAR;

`ifdef NATIVE2WB_TIMEOUT_EN
  logic wd_load, wd_expired;

  // Reload the watchdog on the edge that enters a Wishbone cycle.
  assign wd_load = !busy && ((state_d == WB_WR) || (state_d == WB_RD));

  wb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .load      (wd_load),
    .en        (busy),
    .expired_c (wd_expired)
  );

  assign timeout = busy && wd_expired;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT);
  assign timeout = 1'b0;
`endif

  // State register and registered bus/response outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q            <= IDLE;
      wb_adr             <= '0;
      wb_dat_w           <= '0;
      wb_sel             <= '0;
      wb_we              <= 1'b0;
      wb_cyc             <= 1'b0;
      wb_stb             <= 1'b0;
      rdata_payload_data <= '0;
      rdata_valid        <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      state_q            <= state_d;
      wb_adr             <= adr_d;
      wb_dat_w           <= dat_w_d;
      wb_sel             <= sel_d;
      wb_we              <= we_d;
      wb_cyc             <= cyc_d;
      wb_stb             <= cyc_d;
      rdata_payload_data <= rdata_d;
      rdata_valid        <= rvalid_d;
      bus_error          <= err_d;
    end
  end

  // Next-state and next-output decode; error (or timeout) wins over ack.
  always_comb begin
    state_d  = state_q;
    adr_d    = wb_adr;
    dat_w_d  = wb_dat_w;
    sel_d    = wb_sel;
    we_d     = wb_we;
    cyc_d    = wb_cyc;
    rdata_d  = rdata_payload_data;
    rvalid_d = rdata_valid;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d = cmd_payload_addr + BASE_ADDR;
          we_d  = cmd_payload_we;
          if (cmd_payload_we) begin
            state_d = WDATA;
          end else begin
            state_d = WB_RD;
            cyc_d   = 1'b1;
          end
        end
      end
      WDATA: begin
        if (wdata_valid) begin
          dat_w_d = wdata_payload_data;
          sel_d   = wdata_payload_we;
          cyc_d   = 1'b1;
          state_d = WB_WR;
        end
      end
      WB_WR: begin
        if (wb_err || timeout) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (wb_ack) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WB_RD: begin
        if (wb_err || timeout) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          rvalid_d = 1'b1;
          cyc_d    = 1'b0;
          state_d  = RESP;
        end else if (wb_ack) begin
          rdata_d  = wb_dat_r;
          rvalid_d = 1'b1;
          cyc_d    = 1'b0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rdata_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        cyc_d    = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/native2wb.md
# native2wb

Bridge from the controller's native user port (cmd / wdata / rdata streams) to a classic Wishbone master. It accepts one native command at a time and runs a single non-burst Wishbone cycle for it. Read data comes back on the rdata stream. It sits where a native-port client must reach Wishbone-mapped memory or CSR space: the opposite end of the Wishbone-to-native adapter.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 256, data width; byte-select width is DATA_W/8
- BASE_ADDR, 32'h0200_0000, added to the native address to form the Wishbone address
- TIMEOUT, 1024, watchdog limit in cycles; used only with the timeout feature

Ports:
- sys_clk  in  1  sole clock; everything is on the rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  native command valid
- cmd_ready  out  1  command accepted
- cmd_payload_we  in  1  1 = write, 0 = read
- cmd_payload_addr  in  ADDR_W  native address
- wdata_valid  in  1  write data valid
- wdata_ready  out  1  write data accepted
- wdata_payload_data  in  DATA_W  write data
- wdata_payload_we  in  DATA_W/8  byte enables
- rdata_valid  out  1  read data valid
- rdata_ready  in  1  read data accepted
- rdata_payload_data  out  DATA_W  read data
- wb_adr  out  ADDR_W  Wishbone address
- wb_dat_w  out  DATA_W  Wishbone write data
- wb_dat_r  in  DATA_W  Wishbone read data
- wb_sel  out  DATA_W/8  Wishbone byte selects
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_cti  out  3  constant 3'b000 (classic cycle)
- wb_bte  out  2  constant 2'b00
- wb_ack  in  1  Wishbone acknowledge
- wb_err  in  1  Wishbone error
- bus_error  out  1  one-cycle pulse when a cycle ends in error (or timeout)

## Operation
State machine: IDLE, WDATA, WB_WR, WB_RD, RESP.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register wb_adr = (cmd_payload_addr + BASE_ADDR) mod 2^ADDR_W (carry discarded) and register wb_we = cmd_payload_we.
  - Next state is WDATA if a write, WB_RD if a read.
- **WDATA**
  - wdata_ready=1.
  - On wdata_valid, register wb_dat_w and wb_sel, then go to WB_WR.
  - Write data offered before its command is simply held off, because wdata_ready=0 outside WDATA.
- **WB_WR**
  - wb_cyc=wb_stb=1, wb_we=1.
  - On wb_ack or wb_err, go to IDLE.
  - If the terminating signal is wb_err, pulse bus_error.
- **WB_RD**
  - wb_cyc=wb_stb=1, wb_we=0.
  - On wb_ack, register rdata_payload_data=wb_dat_r and go to RESP.
  - On wb_err, register all-zero data, pulse bus_error, and go to RESP. The native side always receives exactly one response per read.
- **RESP**
  - rdata_valid=1 with the data held stable.
  - On rdata_ready, go to IDLE.
- If wb_ack and wb_err are high together, treat it as error.
- wb_ack and wb_err are ignored outside WB_WR and WB_RD.
- All Wishbone outputs, rdata_valid and bus_error are registered.
- cmd_ready and wdata_ready are decoded from the state.
- Only one transaction is outstanding at a time; there is no pipelining.

## Timing
- Reset values:
  - state=IDLE.
  - wb_cyc, wb_stb, wb_we, rdata_valid, bus_error = 0.
  - wb_adr, wb_dat_w, wb_sel, rdata_payload_data = 0.
  - cmd_ready=1 after reset; wdata_ready=0.
- Reset asserted mid-cycle drops wb_cyc and wb_stb immediately (asynchronously) and discards the transaction.
- Read path:
  - Command accepted at edge N → wb_cyc high from N+1.
  - Ack sampled at edge K → wb_cyc low and rdata_valid high from K+1.
  - With zero-wait ack and rdata_ready held high, a read takes 3 cycles from command to response.
- Write path:
  - Data accepted at edge M → wb_cyc high from M+1.
  - Ack sampled at edge K → wb_cyc low from K+1, with cmd_ready=1 in the same cycle.
- Consecutive commands are separated by at least one IDLE cycle.

## Configuration
- Macro NATIVE2WB_TIMEOUT_EN defined:
  - A watchdog counter clears on entering WB_WR or WB_RD and counts each cycle while there.
  - When the counter reaches TIMEOUT-1 without ack or err, the cycle is terminated exactly as for wb_err: cyc/stb drop, bus_error pulses, and a read returns zero data.
- Macro not defined: no counter is built, and a cycle waits indefinitely for ack or err.

## Structure
- Package native2wb_pkg holds:
  - the state enum;
  - the constants CTI_CLASSIC=3'b000 and BTE_LINEAR=2'b00.
- Optional sub-module wb_watchdog: a loadable down-counter with a clear input and an expiry output, instantiated only under NATIVE2WB_TIMEOUT_EN.

## Test plan
- **Read, ack after 2 wait cycles:** cmd addr 32'h10, we=0; wb_dat_r=256'hA5.. → wb_adr=32'h0200_0010 and wb_we=0; rdata=256'hA5.. delivered once; cyc high for exactly 3 cycles.
- **Write with data 4 cycles late:** cmd addr 32'h20, we=1; wdata 256'h1234, sel=32'hFFFF_FFFF → wb_cyc stays low until the data arrives; wb_adr=32'h0200_0020, wb_dat_w and wb_sel match; no rdata_valid.
- **Read with wb_err:** → bus_error pulses for 1 cycle; rdata_valid with data=0; next cmd accepted normally.
- **Back-pressure:** rdata_ready low for 5 cycles → rdata held stable; cmd_ready=0 throughout; IDLE is reached one cycle after rdata_ready rises.
- **Reset mid-write:** sys_rst_n low while wb_cyc=1 → wb_cyc=0 immediately; after release, cmd_ready=1 and there is no spurious ack-driven transition.
- **Timeout, NATIVE2WB_TIMEOUT_EN with TIMEOUT=8:** read that is never acked → cyc drops after 8 cycles; bus_error pulses; zero data returned. With the macro undefined, cyc stays high.
